// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: default geometry, bundle field widths and the
// bit offsets used to pack a bundle into one storage entry.
package fetch_queue_pkg;

  localparam int FQ_DEPTH  = 4;
  localparam int FQ_DATA_W = 32;
  localparam int FQ_PRED_W = 2;

  // Entry layout, LSB first: instr, pc, pc+4, taken bit, counter state.
  function automatic int entry_w(input int data_w, input int pred_w);
    return 3 * data_w + 1 + pred_w;
  endfunction

  function automatic int off_instr(input int data_w);
    return 0 * data_w;
  endfunction

  function automatic int off_pc(input int data_w);
    return data_w;
  endfunction

  function automatic int off_pc4(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_bp(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_bps(input int data_w);
    return 3 * data_w + 1;
  endfunction

  localparam int FQ_ENTRY_W = entry_w(FQ_DATA_W, FQ_PRED_W);

endpackage

// File: rtl/fetch_queue_mem.sv
// Bundle storage for the fetch queue: one write port, one asynchronous read
// port, cleared by the asynchronous active-low reset.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int WIDTH  = FQ_ENTRY_W,
  parameter int ADDR_W = $clog2(FQ_DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between IF and ID with flush and occupancy count.
// Define FETCH_QUEUE_BYPASS_EN to forward IF straight to ID when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = FQ_DATA_W,
  parameter int PRED_W = FQ_PRED_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     IF_VALID,
  output logic                     IF_READY,
  input  logic [DATA_W-1:0]        Instr1_IF,
  input  logic [DATA_W-1:0]        Instr_PC_IF,
  input  logic [DATA_W-1:0]        Instr_PC_Plus4_IF,
  input  logic                     Branch_prediction_IN,
  input  logic [PRED_W-1:0]        Branch_predictions_IN,
  input  logic                     STALL,
  output logic                     ID_VALID,
  output logic [DATA_W-1:0]        Instr1_OUT,
  output logic [DATA_W-1:0]        Instr_PC_OUT,
  output logic [DATA_W-1:0]        Instr_PC_Plus4,
  output logic                     Branch_prediction_OUT,
  output logic [PRED_W-1:0]        Branch_predictions_OUT,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_w(DATA_W, PRED_W);
  localparam int O_INSTR = off_instr(DATA_W);
  localparam int O_PC    = off_pc(DATA_W);
  localparam int O_PC4   = off_pc4(DATA_W);
  localparam int O_BP    = off_bp(DATA_W);
  localparam int O_BPS   = off_bps(DATA_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] in_entry, head_entry, out_entry;
  logic               empty, push, pop, bypass, bypass_take, wr_en, rd_adv;

  assign in_entry = {Branch_predictions_IN, Branch_prediction_IN,
                     Instr_PC_Plus4_IF, Instr_PC_IF, Instr1_IF};

  assign empty    = (count == '0);
  assign IF_READY = (count != FULL);
  assign push     = IF_VALID && IF_READY;
  assign pop      = ID_VALID && !STALL;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass   = empty && IF_VALID && !FLUSH;
  assign ID_VALID = !FLUSH && (!empty || IF_VALID);
`else
  assign bypass   = 1'b0;
  assign ID_VALID = !empty;
`endif

  // A bypassed bundle that ID takes immediately never touches storage.
  assign bypass_take = bypass && !STALL;
  assign wr_en       = push && !bypass_take && !FLUSH;
  assign rd_adv      = pop && !bypass_take && !FLUSH;

  fetch_queue_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_entry),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_adv)      count <= count + 1'b1;
      else if (!wr_en && rd_adv) count <= count - 1'b1;
    end
  end

  // Payload reads as zero whenever nothing valid is presented to ID.
  always_comb begin
    out_entry = '0;
    if (bypass)        out_entry = in_entry;
    else if (ID_VALID) out_entry = head_entry;
  end

  assign Instr1_OUT             = out_entry[O_INSTR +: DATA_W];
  assign Instr_PC_OUT           = out_entry[O_PC    +: DATA_W];
  assign Instr_PC_Plus4         = out_entry[O_PC4   +: DATA_W];
  assign Branch_prediction_OUT  = out_entry[O_BP];
  assign Branch_predictions_OUT = out_entry[O_BPS   +: PRED_W];
  assign COUNT                  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table plus a random
// phase, both checked against a PC scoreboard of bundles held in the queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int PW    = 2;

  logic          CLK;
  logic          RESET;
  logic          FLUSH;
  logic          IF_VALID;
  logic          IF_READY;
  logic [DW-1:0] Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;
  logic          Branch_prediction_IN;
  logic [PW-1:0] Branch_predictions_IN;
  logic          STALL;
  logic          ID_VALID;
  logic [DW-1:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4;
  logic          Branch_prediction_OUT;
  logic [PW-1:0] Branch_predictions_OUT;
  logic [2:0]    COUNT;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DW), .PRED_W(PW)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .FLUSH                  (FLUSH),
    .IF_VALID               (IF_VALID),
    .IF_READY               (IF_READY),
    .Instr1_IF              (Instr1_IF),
    .Instr_PC_IF            (Instr_PC_IF),
    .Instr_PC_Plus4_IF      (Instr_PC_Plus4_IF),
    .Branch_prediction_IN   (Branch_prediction_IN),
    .Branch_predictions_IN  (Branch_predictions_IN),
    .STALL                  (STALL),
    .ID_VALID               (ID_VALID),
    .Instr1_OUT             (Instr1_OUT),
    .Instr_PC_OUT           (Instr_PC_OUT),
    .Instr_PC_Plus4         (Instr_PC_Plus4),
    .Branch_prediction_OUT  (Branch_prediction_OUT),
    .Branch_predictions_OUT (Branch_predictions_OUT),
    .COUNT                  (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic        st;
    logic        fl;
    logic [31:0] pc;
    int          cnt;
    logic        rdy;
    logic        val;
    logic [31:0] head;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  // Every bundle field is derived from its PC so a PC alone identifies it.
  function automatic logic [31:0] mkInstr(input logic [31:0] pc);
    return {pc[15:0], 16'h1234} ^ 32'h0F0F_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_pc"},    Instr_PC_OUT, pc);
    checkOutput({tag, "_instr"}, Instr1_OUT, mkInstr(pc));
    checkOutput({tag, "_pc4"},   Instr_PC_Plus4, pc + 32'd4);
    checkOutput({tag, "_pred"},  {Branch_prediction_OUT, Branch_predictions_OUT},
                {pc[2], pc[3:2]});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_zero"},
                {Instr_PC_OUT, Instr1_OUT ^ Instr_PC_Plus4,
                 Branch_prediction_OUT, Branch_predictions_OUT}, 64'd0);
  endtask

  // One cycle: drive at edge+2, check combinational outputs just before the
  // next edge against the scoreboard, then idle the inputs and update it.
  task automatic applyStimulus(input logic iv, input logic st, input logic fl,
                               input logic [31:0] pc);
    int   n;
    logic exp_valid;
    logic byp;
    IF_VALID              = iv;
    STALL                 = st;
    FLUSH                 = fl;
    Instr_PC_IF           = pc;
    Instr1_IF             = mkInstr(pc);
    Instr_PC_Plus4_IF     = pc + 32'd4;
    Branch_prediction_IN  = pc[2];
    Branch_predictions_IN = pc[3:2];
    #3;
    n = sb.size();
`ifdef FETCH_QUEUE_BYPASS_EN
    byp       = (n == 0) && iv && !fl;
    exp_valid = !fl && (n != 0 || iv);
`else
    byp       = 1'b0;
    exp_valid = (n != 0);
`endif
    checkOutput("if_ready", IF_READY, (n != DEPTH));
    checkOutput("count", COUNT, n);
    checkOutput("id_valid", ID_VALID, exp_valid);
    if (exp_valid) checkHead("head", (n != 0) ? sb[0] : pc);
    else           checkIdle("empty");
    @(posedge CLK);
    #1;
    IF_VALID = 1'b0;
    STALL    = 1'b1;
    FLUSH    = 1'b0;
    if (fl) sb.delete();
    else if (!(byp && !st)) begin
      if (exp_valid && !st) void'(sb.pop_front());
      if (iv && n != DEPTH) sb.push_back(pc);
    end
    #1;
  endtask

  function automatic void addVec(input logic iv, input logic st, input logic fl,
                                 input logic [31:0] pc, input int cnt,
                                 input logic rdy, input logic val,
                                 input logic [31:0] head);
    vec_t v;
    v.iv = iv; v.st = st; v.fl = fl; v.pc = pc;
    v.cnt = cnt; v.rdy = rdy; v.val = val; v.head = head;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] pc;

    RESET = 1'b0; FLUSH = 1'b0; IF_VALID = 1'b0; STALL = 1'b1;
    Instr1_IF = '0; Instr_PC_IF = '0; Instr_PC_Plus4_IF = '0;
    Branch_prediction_IN = 1'b0; Branch_predictions_IN = '0;

    //     iv  st  fl  pc      cnt rdy val head
    addVec(1, 1, 0, 32'h00, 1, 1, 1, 32'h00);
    addVec(1, 1, 0, 32'h04, 2, 1, 1, 32'h00);
    addVec(1, 1, 0, 32'h08, 3, 1, 1, 32'h00);
    addVec(1, 1, 0, 32'h0C, 4, 0, 1, 32'h00);
    addVec(1, 1, 0, 32'h10, 4, 0, 1, 32'h00);
    addVec(1, 0, 0, 32'h10, 3, 1, 1, 32'h04);
    addVec(1, 0, 0, 32'h10, 3, 1, 1, 32'h08);
    addVec(1, 0, 0, 32'h14, 3, 1, 1, 32'h0C);
    addVec(1, 0, 0, 32'h18, 3, 1, 1, 32'h10);
    addVec(1, 0, 0, 32'h1C, 3, 1, 1, 32'h14);
    addVec(0, 0, 0, 32'h00, 2, 1, 1, 32'h18);
    addVec(0, 0, 0, 32'h00, 1, 1, 1, 32'h1C);
    addVec(0, 0, 0, 32'h00, 0, 1, 0, 32'h00);
    addVec(1, 1, 0, 32'h20, 1, 1, 1, 32'h20);
    addVec(1, 1, 0, 32'h24, 2, 1, 1, 32'h20);
    addVec(1, 0, 0, 32'h28, 2, 1, 1, 32'h24);
    addVec(1, 1, 0, 32'h2C, 3, 1, 1, 32'h24);
    addVec(1, 1, 1, 32'h30, 0, 1, 0, 32'h00);
`ifdef FETCH_QUEUE_BYPASS_EN
    addVec(1, 0, 0, 32'h40, 0, 1, 0, 32'h00);
`else
    addVec(1, 0, 0, 32'h40, 1, 1, 1, 32'h40);
`endif
    addVec(0, 0, 0, 32'h00, 0, 1, 0, 32'h00);
    addVec(1, 1, 0, 32'h40, 1, 1, 1, 32'h40);
    addVec(0, 0, 0, 32'h00, 0, 1, 0, 32'h00);

    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    #1;
    checkOutput("rst_count", COUNT, 0);
    checkOutput("rst_if_ready", IF_READY, 1);
    checkOutput("rst_id_valid", ID_VALID, 0);
    checkIdle("rst");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, vecs[i].st, vecs[i].fl, vecs[i].pc);
      checkOutput($sformatf("vec%0d_count", i), COUNT, vecs[i].cnt);
      checkOutput($sformatf("vec%0d_ready", i), IF_READY, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), ID_VALID, vecs[i].val);
      if (vecs[i].val) checkHead($sformatf("vec%0d", i), vecs[i].head);
      else             checkIdle($sformatf("vec%0d", i));
    end

    pc = 32'h100;
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), pc);
      pc = pc + 32'd4;
    end

    // Asynchronous reset in the middle of a cycle with bundles buffered.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h500);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h504);
    #2 RESET = 1'b0;
    #1;
    checkOutput("async_rst_count", COUNT, 0);
    checkOutput("async_rst_id_valid", ID_VALID, 0);
    checkIdle("async_rst");
    @(posedge CLK);
    #1 RESET = 1'b1;
    sb.delete();
    #1;
    checkOutput("post_rst_if_ready", IF_READY, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h600);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_rst_count", COUNT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between IF and ID, replacing the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched bundles (instruction, PC, PC+4, branch prediction bits) with a valid/ready handshake toward IF and a stall-driven dequeue toward ID. IF can therefore keep fetching while ID is stalled. FLUSH discards all buffered bundles on branch mispredict or redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- DATA_W, 32, width of instruction and PC fields
- PRED_W, 2, width of multi-bit prediction field
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous queue clear; highest priority after RESET
- IF_VALID  in  1  IF presents a bundle
- IF_READY  out  1  queue can accept a bundle
- Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF  in  DATA_W each  incoming bundle fields
- Branch_prediction_IN  in  1  taken/not-taken prediction
- Branch_predictions_IN  in  PRED_W  prediction counter state
- STALL  in  1  ID cannot accept this cycle
- ID_VALID  out  1  head bundle is valid
- Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4  out  DATA_W each  head bundle fields
- Branch_prediction_OUT  out  1, Branch_predictions_OUT  out  PRED_W  head prediction fields
- COUNT  out  $clog2(DEPTH)+1  current occupancy

## Operation
- push = IF_VALID && IF_READY; pop = ID_VALID && !STALL.
- IF_READY = (COUNT != DEPTH). It has no combinational dependency on STALL, so a full queue refuses a push even when a pop occurs in the same cycle.
- Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Push writes entry[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- COUNT update: +1 on push only; −1 on pop only; unchanged on simultaneous push and pop. It never exceeds DEPTH and never goes below 0.
- Outputs are driven combinationally from entry[rd_ptr] when COUNT>0. When empty, ID_VALID=0 and all payload outputs are 0.
- FLUSH at a clock edge: pointers and COUNT go to 0. Any push or pop in that cycle is discarded.
- Async RESET: pointers, COUNT and storage go to 0, so every output reads 0. IF_READY reads 1 once RESET deasserts.

## Timing
- Without bypass: a bundle pushed at edge k is presented at the ID outputs from edge k onward when the queue was empty. Latency is 1 cycle.
- With bypass, when the queue is empty (see Configuration), latency is 0 cycles: the IF fields appear at the ID outputs in the same cycle.
- A head entry is held stable for as long as STALL=1.
- Back-to-back push and pop with COUNT=1 sustain one bundle per cycle.
- Reset asserted mid-operation takes effect immediately, not at a clock edge. Buffered bundles are lost.
- FLUSH and RESET are never asserted together by design. If they are, RESET wins.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When COUNT==0 and IF_VALID=1, the outputs show the IF inputs combinationally and ID_VALID=1.
  - If STALL=0 in that cycle, the bundle is consumed with no write and COUNT stays 0.
  - If STALL=1, the bundle is written normally and COUNT becomes 1.
  - FLUSH suppresses the bypass: ID_VALID=0 in a flush cycle.
- FETCH_QUEUE_BYPASS_EN undefined: the outputs come only from storage, and ID_VALID=0 whenever COUNT==0.

## Structure
- Shared constants go in config.v:
  - field widths
  - derived entry width ENTRY_W = 3*DATA_W + 1 + PRED_W
  - field bit offsets used to pack and unpack entries
  - default DEPTH
- One sub-module, fetch_queue_mem: a DEPTH×ENTRY_W register file with one write port and one asynchronous read port. It is reset to zero by RESET.
- Pointer, count, handshake and bypass logic live in fetch_queue.

## Test plan
- Reset then idle: RESET low for 2 cycles, then release → all outputs are 0, IF_READY=1, COUNT=0, ID_VALID=0.
- Fill: DEPTH=4, STALL=1, push PCs 0x00,0x04,0x08,0x0C → COUNT=4, IF_READY=0, and the head shows Instr_PC_OUT=0x00. A fifth push is refused and COUNT stays 4.
- Drain with wrap: from full, drop STALL and push PCs 0x10–0x1C over 8 cycles → the outputs show PCs in order 0x00..0x1C with no gaps or duplicates, and the pointers wrap twice.
- Simultaneous push and pop at COUNT=2 → COUNT stays 2, and the head advances from 0x20 to 0x24.
- Flush: COUNT=3 with FLUSH=1 and IF_VALID=1 in the same cycle → next cycle COUNT=0, ID_VALID=0, and the pushed bundle is absent from the outputs.
- Bypass (with FETCH_QUEUE_BYPASS_EN): empty queue, push PC 0x40 with STALL=0 → ID_VALID=1 in the same cycle and COUNT stays 0. Repeating with STALL=1 → COUNT=1, and the head is 0x40 on the next cycle.
